// File: rtl/scatter_deselector.sv
// -----------------------------------------------------------------------------
// scatter_deselector
//
// Purpose:
//   Inverse of the nibble-gather selector. Accepts 16-bit beats made of four
//   4-bit lanes and scatters every lane into one nibble of one of two 32-bit
//   accumulators (A or B). Beats accumulate until IN_LAST or until MAX_BEATS
//   beats have been taken. The assembled pair is then held on a valid/ready
//   output until the consumer takes it.
//
// Parameters:
//   CLEAR_VALUE : value loaded into both accumulators at reset and on handoff
//   MAX_BEATS   : beats per frame before a forced close (legal range 1..15)
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET_L    in   asynchronous active-low reset
//   IN_VALID   in   beat valid
//   IN_READY   out  block can accept a beat (IDLE/ACCUM, not in reset)
//   IN_DATA    in   lane i = IN_DATA[4i+3:4i]
//   IN_LAST    in   final beat of the frame
//   SEL        in   SEL[i]=0 -> lane i goes to A, 1 -> lane i goes to B
//   dst_A      in   dst_A[3i+2:3i] = nibble index in A for lane i
//   dst_B      in   dst_B[3i+2:3i] = nibble index in B for lane i
//   OUT_VALID  out  OUT_A/OUT_B hold a completed frame
//   OUT_READY  in   consumer accepts the frame
//   OUT_A      out  assembled word A
//   OUT_B      out  assembled word B
//   BEAT_CNT   out  beats accepted in current/held frame
//   OVERFLOW   out  frame closed by MAX_BEATS without IN_LAST
//
// Optional feature (macro SCATTER_MASK_EN):
//   OUT_MASK_A/OUT_MASK_B [7:0] : bit k set when nibble k of A/B was written
//   by any beat of the frame. Same timing as the data, cleared on handoff.
// -----------------------------------------------------------------------------
module scatter_deselector #(
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000,
    parameter int unsigned MAX_BEATS   = 8
) (
    input  logic        CLK,
    input  logic        RESET_L,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] IN_DATA,
    input  logic        IN_LAST,
    input  logic [3:0]  SEL,
    input  logic [11:0] dst_A,
    input  logic [11:0] dst_B,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_A,
    output logic [31:0] OUT_B,
    output logic [3:0]  BEAT_CNT,
    output logic        OVERFLOW
`ifdef SCATTER_MASK_EN
    ,
    output logic [7:0]  OUT_MASK_A,
    output logic [7:0]  OUT_MASK_B
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [4:0] MAX_BEATS_C = 5'(MAX_BEATS);

    state_t      state_r;
    logic [31:0] acc_a_r;
    logic [31:0] acc_b_r;
    logic [3:0]  beat_cnt_r;
    logic        overflow_r;
    logic        out_valid_r;

    logic        beat_acc_s;
    logic [31:0] nxt_a_s;
    logic [31:0] nxt_b_s;
    logic [4:0]  cnt_inc_s;
    logic        limit_s;
    logic        handoff_s;

    // Ready is a pure decode of the state register, forced low while reset is held.
    assign IN_READY   = RESET_L & (state_r != ST_HOLD);
    assign beat_acc_s = IN_VALID & (state_r != ST_HOLD);
    assign handoff_s  = (state_r == ST_HOLD) & OUT_READY;
    assign cnt_inc_s  = {1'b0, beat_cnt_r} + 5'd1;
    assign limit_s    = (cnt_inc_s == MAX_BEATS_C);

    assign OUT_A     = acc_a_r;
    assign OUT_B     = acc_b_r;
    assign BEAT_CNT  = beat_cnt_r;
    assign OVERFLOW  = overflow_r;
    assign OUT_VALID = out_valid_r;

    // Scatter the four lanes of the current beat into next-value copies of A/B.
    // Lanes are applied in ascending order so the highest lane wins a collision.
    always_comb begin
        nxt_a_s = acc_a_r;
        nxt_b_s = acc_b_r;
        for (int i = 32'sd0; i < 32'sd4; i++) begin
            if (SEL[i] == 1'b0) begin
                nxt_a_s[{dst_A[3*i +: 3], 2'b00} +: 4] = IN_DATA[4*i +: 4];
            end else begin
                nxt_b_s[{dst_B[3*i +: 3], 2'b00} +: 4] = IN_DATA[4*i +: 4];
            end
        end
    end

    // Frame FSM with accumulators, beat counter and registered status outputs.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_r     <= ST_IDLE;
            acc_a_r     <= CLEAR_VALUE;
            acc_b_r     <= CLEAR_VALUE;
            beat_cnt_r  <= 4'd0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ACCUM: begin
                    if (beat_acc_s) begin
                        acc_a_r    <= nxt_a_s;
                        acc_b_r    <= nxt_b_s;
                        beat_cnt_r <= cnt_inc_s[3:0];
                        // IN_LAST takes priority: a frame that ends exactly
                        // at the limit is a normal close, not an overflow.
                        if (IN_LAST) begin
                            state_r     <= ST_HOLD;
                            overflow_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else if (limit_s) begin
                            state_r     <= ST_HOLD;
                            overflow_r  <= 1'b1;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (OUT_READY) begin
                        state_r     <= ST_IDLE;
                        acc_a_r     <= CLEAR_VALUE;
                        acc_b_r     <= CLEAR_VALUE;
                        beat_cnt_r  <= 4'd0;
                        overflow_r  <= 1'b0;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean empty frame.
                    state_r     <= ST_IDLE;
                    acc_a_r     <= CLEAR_VALUE;
                    acc_b_r     <= CLEAR_VALUE;
                    beat_cnt_r  <= 4'd0;
                    overflow_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCATTER_MASK_EN
    logic [7:0] mask_a_r;
    logic [7:0] mask_b_r;
    logic [7:0] wr_a_s;
    logic [7:0] wr_b_s;

    assign OUT_MASK_A = mask_a_r;
    assign OUT_MASK_B = mask_b_r;

    // Decode which nibbles of A/B the current beat touches.
    always_comb begin
        wr_a_s = 8'h00;
        wr_b_s = 8'h00;
        for (int i = 32'sd0; i < 32'sd4; i++) begin
            if (SEL[i] == 1'b0) begin
                wr_a_s[dst_A[3*i +: 3]] = 1'b1;
            end else begin
                wr_b_s[dst_B[3*i +: 3]] = 1'b1;
            end
        end
    end

    // Sticky written-nibble masks, following the accumulator update timing.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            mask_a_r <= 8'h00;
            mask_b_r <= 8'h00;
        end else if (handoff_s) begin
            mask_a_r <= 8'h00;
            mask_b_r <= 8'h00;
        end else if (beat_acc_s) begin
            mask_a_r <= mask_a_r | wr_a_s;
            mask_b_r <= mask_b_r | wr_b_s;
        end else begin
            mask_a_r <= mask_a_r;
            mask_b_r <= mask_b_r;
        end
    end
`endif

endmodule

// File: tb/tb_scatter_deselector.sv
// -----------------------------------------------------------------------------
// tb_scatter_deselector
//
// Self-checking bench for scatter_deselector (MAX_BEATS=3, CLEAR_VALUE=0).
// Directed frames from the test plan followed by randomized traffic, all
// compared against a nibble-array frame model kept in the bench.
// -----------------------------------------------------------------------------
module tb_scatter_deselector;

    localparam int          MAXB = 3;
    localparam logic [31:0] CLR  = 32'h0000_0000;

    logic        CLK;
    logic        RESET_L;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] IN_DATA;
    logic        IN_LAST;
    logic [3:0]  SEL;
    logic [11:0] dst_A;
    logic [11:0] dst_B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_A;
    logic [31:0] OUT_B;
    logic [3:0]  BEAT_CNT;
    logic        OVERFLOW;
`ifdef SCATTER_MASK_EN
    logic [7:0]  OUT_MASK_A;
    logic [7:0]  OUT_MASK_B;
`endif

    scatter_deselector #(
        .CLEAR_VALUE (CLR),
        .MAX_BEATS   (MAXB)
    ) u_dut (
        .CLK        (CLK),
        .RESET_L    (RESET_L),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_DATA    (IN_DATA),
        .IN_LAST    (IN_LAST),
        .SEL        (SEL),
        .dst_A      (dst_A),
        .dst_B      (dst_B),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_A      (OUT_A),
        .OUT_B      (OUT_B),
        .BEAT_CNT   (BEAT_CNT),
        .OVERFLOW   (OVERFLOW)
`ifdef SCATTER_MASK_EN
        ,
        .OUT_MASK_A (OUT_MASK_A),
        .OUT_MASK_B (OUT_MASK_B)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame model: one nibble per array entry, plus written flags.
    logic [3:0] m_na [8];
    logic [3:0] m_nb [8];
    bit         m_wa [8];
    bit         m_wb [8];
    bit         m_hold;
    int         m_cnt;
    bit         m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_n(input logic [3:0] n [8]);
        logic [31:0] v;
        for (int k = 0; k < 8; k++) v[4*k +: 4] = n[k];
        return v;
    endfunction

    function automatic logic [7:0] pack_w(input bit w [8]);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = w[k];
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_na[k] = CLR[4*k +: 4];
            m_nb[k] = CLR[4*k +: 4];
            m_wa[k] = 1'b0;
            m_wb[k] = 1'b0;
        end
        m_hold = 1'b0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (m_hold) begin
            if (OUT_READY) model_clear();
        end else if (IN_VALID) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                if (!SEL[i]) begin
                    k = int'(dst_A[3*i +: 3]);
                    m_na[k] = IN_DATA[4*i +: 4];
                    m_wa[k] = 1'b1;
                end else begin
                    k = int'(dst_B[3*i +: 3]);
                    m_nb[k] = IN_DATA[4*i +: 4];
                    m_wb[k] = 1'b1;
                end
            end
            m_cnt++;
            if (IN_LAST) begin
                m_hold = 1'b1;
                m_ovf  = 1'b0;
            end else if (m_cnt == MAXB) begin
                m_hold = 1'b1;
                m_ovf  = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("in_ready",  32'(IN_READY),  32'(!m_hold));
        check("out_valid", 32'(OUT_VALID), 32'(m_hold));
        check("out_a",     OUT_A,          pack_n(m_na));
        check("out_b",     OUT_B,          pack_n(m_nb));
        check("beat_cnt",  32'(BEAT_CNT),  32'(m_cnt));
        check("overflow",  32'(OVERFLOW),  32'(m_ovf));
`ifdef SCATTER_MASK_EN
        check("mask_a",    32'(OUT_MASK_A), 32'(pack_w(m_wa)));
        check("mask_b",    32'(OUT_MASK_B), 32'(pack_w(m_wb)));
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic beat(input logic [15:0] d, input logic [3:0] s,
                        input logic [11:0] da, input logic [11:0] db, input logic l);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        SEL      = s;
        dst_A    = da;
        dst_B    = db;
        IN_LAST  = l;
        cycle();
    endtask

    task automatic idle_in();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    initial begin
        RESET_L   = 1'b0;
        IN_VALID  = 1'b0;
        IN_DATA   = 16'h0000;
        IN_LAST   = 1'b0;
        SEL       = 4'h0;
        dst_A     = 12'h000;
        dst_B     = 12'h000;
        OUT_READY = 1'b0;
        model_clear();

        // Reset state while reset is held.
        #12;
        check("rst_in_ready",  32'(IN_READY),  32'd0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_a",     OUT_A,          CLR);
        check("rst_beat_cnt",  32'(BEAT_CNT),  32'd0);
        @(negedge CLK);
        RESET_L = 1'b1;
        #1;
        check_outputs();

        // Single beat: lanes 0,1 to B nibbles 0,1; lanes 2,3 to A nibbles 0,1.
        beat(16'hABCD, 4'b0011, 12'h200, 12'h008, 1'b1);
        check("t1_out_a", OUT_A, 32'h0000_00AB);
        check("t1_out_b", OUT_B, 32'h0000_00CD);
        check("t1_cnt",   32'(BEAT_CNT), 32'd1);
        idle_in();
        OUT_READY = 1'b1;
        cycle();

        // Two beats with OUT_READY already high: frame still holds one cycle.
        beat(16'h1234, 4'b0000, 12'h688, 12'h000, 1'b0);
        beat(16'h5678, 4'b0000, 12'hFAC, 12'h000, 1'b1);
        check("t2_out_a",  OUT_A, 32'h5678_1234);
        check("t2_out_b",  OUT_B, CLR);
        check("t2_cnt",    32'(BEAT_CNT), 32'd2);
        check("t2_valid",  32'(OUT_VALID), 32'd1);
        idle_in();
        cycle();

        // Collision: every lane targets A nibble 0, lane 3 wins.
        OUT_READY = 1'b0;
        beat(16'hF00E, 4'b0000, 12'h000, 12'h000, 1'b1);
        check("t3_out_a", OUT_A, 32'h0000_000F);

        // Backpressure in HOLD with IN_VALID driven.
        for (int c = 0; c < 5; c++) begin
            IN_VALID = 1'b1;
            IN_DATA  = 16'($urandom);
            SEL      = 4'($urandom);
            dst_A    = 12'($urandom);
            dst_B    = 12'($urandom);
            IN_LAST  = 1'b0;
            cycle();
        end
        check("t4_hold_a",     OUT_A, 32'h0000_000F);
        check("t4_hold_ready", 32'(IN_READY), 32'd0);
        idle_in();
        OUT_READY = 1'b1;
        cycle();
        check("t4_rel_valid", 32'(OUT_VALID), 32'd0);
        check("t4_rel_a",     OUT_A, 32'h0000_0000);
        check("t4_rel_ready", 32'(IN_READY), 32'd1);

        // Overflow at MAX_BEATS, then limit coinciding with IN_LAST.
        OUT_READY = 1'b0;
        beat(16'h1111, 4'b0101, 12'h123, 12'h456, 1'b0);
        beat(16'h2222, 4'b1010, 12'h789, 12'hABC, 1'b0);
        beat(16'h3333, 4'b1111, 12'hDEF, 12'h210, 1'b0);
        check("t5_ovf", 32'(OVERFLOW), 32'd1);
        check("t5_cnt", 32'(BEAT_CNT), 32'd3);
        idle_in();
        OUT_READY = 1'b1;
        cycle();
        OUT_READY = 1'b0;
        beat(16'h4444, 4'b0000, 12'h111, 12'h000, 1'b0);
        beat(16'h5555, 4'b1111, 12'h000, 12'h222, 1'b0);
        beat(16'h6666, 4'b0110, 12'h333, 12'h444, 1'b1);
        check("t5_last_ovf", 32'(OVERFLOW), 32'd0);
        check("t5_last_cnt", 32'(BEAT_CNT), 32'd3);
        idle_in();
        OUT_READY = 1'b1;
        cycle();

        // Async reset between edges after two beats.
        OUT_READY = 1'b0;
        beat(16'h9ABC, 4'b0011, 12'h688, 12'hFAC, 1'b0);
        beat(16'hDEF1, 4'b1100, 12'hFAC, 12'h688, 1'b0);
        idle_in();
        #3;
        RESET_L = 1'b0;
        #1;
        check("t6_rst_a",     OUT_A, CLR);
        check("t6_rst_b",     OUT_B, CLR);
        check("t6_rst_cnt",   32'(BEAT_CNT), 32'd0);
        check("t6_rst_ready", 32'(IN_READY), 32'd0);
`ifdef SCATTER_MASK_EN
        check("t6_rst_mask_a", 32'(OUT_MASK_A), 32'd0);
        check("t6_rst_mask_b", 32'(OUT_MASK_B), 32'd0);
`endif
        model_clear();
        #2;
        RESET_L = 1'b1;
        #1;
        check_outputs();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            IN_VALID  = ($urandom % 4) != 0;
            IN_DATA   = 16'($urandom);
            SEL       = 4'($urandom);
            dst_A     = 12'($urandom);
            dst_B     = 12'($urandom);
            IN_LAST   = ($urandom % 5) == 0;
            OUT_READY = ($urandom % 3) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scatter_deselector.md
Name: scatter_deselector

Overview:
- Inverse of the nibble-gather selector: accepts 16-bit beats of four 4-bit lanes and scatters each lane into one nibble of one of two 32-bit destination words (A or B).
- Each lane's destination is set by a per-lane SEL bit and a 3-bit nibble index.
- Beats accumulate until IN_LAST, or until the MAX_BEATS beat limit is reached; the assembled pair is then presented on a valid/ready output.
- Sits downstream of the selector path and rebuilds DATA_A/DATA_B-style words.

Parameters:
- CLEAR_VALUE, 32'h0: value loaded into both accumulators at reset and after each output handoff.
- MAX_BEATS, 8: beats accepted per frame before a forced close; legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock
- RESET_L  input  1  asynchronous active-low reset
- IN_VALID  input  1  beat valid
- IN_READY  output  1  block can accept a beat
- IN_DATA  input  16  lane i = IN_DATA[4i+3:4i], i=0..3
- IN_LAST  input  1  final beat of frame
- SEL  input  4  SEL[i]=0: lane i goes to A; SEL[i]=1: lane i goes to B
- dst_A  input  12  dst_A[3i+2:3i] = nibble index in A for lane i
- dst_B  input  12  dst_B[3i+2:3i] = nibble index in B for lane i
- OUT_VALID  output  1  OUT_A/OUT_B hold a completed frame
- OUT_READY  input  1  consumer accepts frame
- OUT_A  output  32  assembled word A
- OUT_B  output  32  assembled word B
- BEAT_CNT  output  4  beats accepted in current/held frame
- OVERFLOW  output  1  frame closed by MAX_BEATS without IN_LAST

Behaviour:
- Reset (RESET_L=0, async): state IDLE, OUT_A=OUT_B=CLEAR_VALUE, BEAT_CNT=0, OVERFLOW=0, OUT_VALID=0, IN_READY=0 while reset is asserted.
- States:
  - IDLE: no beat yet. IN_READY=1.
  - ACCUM: at least one beat accepted. IN_READY=1.
  - HOLD: frame complete. IN_READY=0, OUT_VALID=1.
- A beat is accepted when IN_VALID && IN_READY at a rising edge.
- Per accepted beat, for each lane i: the target register is A if SEL[i]=0, else B. The target nibble [4k+3:4k] is written with the lane's nibble (k from dst_A or dst_B). Unwritten nibbles keep their value. The update is visible on OUT_A/OUT_B the cycle after acceptance.
- Same-beat collision (two lanes hitting the same nibble of the same register): the highest lane index wins.
- Across beats, later beats overwrite earlier ones.
- BEAT_CNT increments by 1 per accepted beat.
- Transitions:
  - IDLE -> ACCUM on an accepted beat with IN_LAST=0 and BEAT_CNT+1 < MAX_BEATS.
  - IDLE/ACCUM -> HOLD on an accepted beat with IN_LAST=1. OVERFLOW=0.
  - IDLE/ACCUM -> HOLD on an accepted beat with IN_LAST=0 and BEAT_CNT+1 == MAX_BEATS. OVERFLOW=1.
  - Priority: IN_LAST wins; OVERFLOW=0 if IN_LAST and the limit coincide.
  - HOLD -> IDLE when OUT_READY=1. On the same edge, accumulators reload CLEAR_VALUE and BEAT_CNT and OVERFLOW clear.
- Latency: OUT_VALID rises the cycle after the closing beat is accepted. OUT_READY may already be high, so a frame holds at least 1 cycle.
- In HOLD, OUT_A, OUT_B, BEAT_CNT and OVERFLOW are stable; IN_VALID is ignored (no acceptance).
- OUT_READY outside HOLD has no effect.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values immediately.
- X on SEL/dst_* is ignored while IN_VALID=0.

Optional Feature:
- Macro: SCATTER_MASK_EN.
- Defined: adds outputs OUT_MASK_A[7:0] and OUT_MASK_B[7:0].
  - Bit k is set when nibble k of A/B was written by any beat in the frame.
  - Updated with the same timing as the data; cleared at reset and on handoff.
  - Stable in HOLD.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single beat: IN_DATA=16'hABCD, SEL=4'b0011, dst_B[5:0]={3'd1,3'd0}, dst_A[11:6]={3'd1,3'd0}, IN_LAST=1 -> next cycle OUT_VALID=1, OUT_A=32'h000000AB, OUT_B=32'h000000CD, BEAT_CNT=1, OVERFLOW=0.
- Two beats: beat 1 IN_DATA=16'h1234, SEL=0, dst_A={3'd3,3'd2,3'd1,3'd0}; beat 2 IN_DATA=16'h5678, SEL=0, dst_A={3'd7,3'd6,3'd5,3'd4}, IN_LAST=1 -> OUT_A=32'h56781234, OUT_B=CLEAR_VALUE, BEAT_CNT=2.
- Collision: IN_DATA=16'hF00E, SEL=0, all dst_A fields=0, IN_LAST=1 -> OUT_A[3:0]=4'hF (lane 3 wins), other nibbles 0.
- Backpressure: hold OUT_READY=0 for 5 cycles in HOLD while driving IN_VALID=1 -> IN_READY=0, outputs unchanged. OUT_READY=1 -> next cycle OUT_VALID=0, OUT_A=OUT_B=0, IN_READY=1.
- Overflow with MAX_BEATS=3: three beats with IN_LAST=0 -> HOLD, OVERFLOW=1, BEAT_CNT=3. Repeat with IN_LAST=1 on beat 3 -> OVERFLOW=0.
- Async reset asserted mid-frame after 2 beats, between clock edges -> OUT_A/OUT_B = CLEAR_VALUE and BEAT_CNT=0 immediately. With SCATTER_MASK_EN, masks = 0.
